// File: rtl/sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder_pkg
// Purpose  : Shared types and constants for the on-chip SRAM responder.
//            Holds the FSM state encoding, data width, byte-enable type and
//            the latency counter width.
// Ports    : none (package)
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
package sram_responder_pkg;

  localparam int DATA_W = 16;
  localparam int LAT_W  = 4;

  // Bit [1] = upper byte Data[15:8], bit [0] = lower byte Data[7:0].
  typedef logic [1:0] byte_en_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2,
    WR_HOLD  = 2'd3
  } state_t;

endpackage : sram_responder_pkg
`default_nettype wire

// File: rtl/sram_responder_array.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder_array
// Purpose  : DEPTH x 16 word storage with per-byte write enables and a
//            one-cycle synchronous read.
// Ports    : clk      - clock
//            i_we     - write strobe (active high)
//            i_be     - byte write enables, [1]=Data[15:8], [0]=Data[7:0]
//            i_waddr  - write word address
//            i_wdata  - write data
//            i_raddr  - read word address
//            o_rdata  - read data, valid the cycle after i_raddr is presented
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
module sram_responder_array
  import sram_responder_pkg::*;
#(
  parameter int DEPTH = 65536,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  byte_en_t          i_be,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we && i_be[1]) r_mem[i_waddr][15:8] <= i_wdata[15:8];
    if (i_we && i_be[0]) r_mem[i_waddr][7:0]  <= i_wdata[7:0];
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule : sram_responder_array
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder
// Purpose  : On-chip stand-in for the external 1Mx16 SRAM. Decodes the
//            active-low CE/OE/WE/UB/LB pin interface with a configurable
//            read latency and returns read data plus per-byte drive enables
//            for the top-level tristate.
// Ports    : Clk        - clock, all state changes on rising edge
//            Reset      - synchronous, active-low reset
//            CE/OE/WE   - chip/output/write enable, active low
//            UB/LB      - upper/lower byte enable, active low
//            ADDR       - word address (ADDR_W bits)
//            Data_In    - bus value driven by the CPU
//            Data_Out   - read data toward the bus (disabled lanes are 8'h00)
//            Data_Drive - per-byte drive enable, [1]=upper, [0]=lower
//            Busy       - read waiting out its latency or write pending
//            Contention - sticky bus-conflict flag (only with macro)
// Macros   : SRAM_RESPONDER_CONTENTION_CHECK_EN - adds the Contention output
// Revision : 1.0 - initial release
// ============================================================================
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DEPTH    = 65536,
  parameter int READ_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CE,
  input  logic              OE,
  input  logic              WE,
  input  logic              UB,
  input  logic              LB,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_In,
  output logic [DATA_W-1:0] Data_Out,
  output byte_en_t          Data_Drive,
  output logic              Busy
`ifdef SRAM_RESPONDER_CONTENTION_CHECK_EN
  ,
  output logic              Contention
`endif
);

  localparam int                AW         = $clog2(DEPTH);
  localparam logic [LAT_W-1:0]  C_LAT_LOAD = LAT_W'(READ_LAT - 1);
  localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W + 1)'(DEPTH);

  state_t              r_state;
  logic [LAT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_cap_addr;
  logic [DATA_W-1:0]   r_cap_data;
  byte_en_t            r_cap_be;     // active-high copy of ~{UB,LB}
  logic                r_cap_inr;    // captured address lies inside DEPTH
  logic                r_rd_inr;     // r_cap_inr aligned with the array output
  byte_en_t            r_drive;

  logic                w_wr;
  logic                w_rd;
  logic                w_addr_chg;
  logic                w_in_range;
  logic                w_commit;
  logic [DATA_W-1:0]   w_rdata;

  // Write wins over OE whenever CE is low.
  assign w_wr       = ~CE & ~WE;
  assign w_rd       = ~CE &  WE & ~OE;
  assign w_addr_chg = (ADDR != r_cap_addr);
  assign w_in_range = ({1'b0, ADDR} < C_DEPTH);

  // Commit fires on the first edge the write is no longer seen, using the
  // values captured on the last write cycle. A reset edge discards it, and
  // out-of-range writes never reach the array.
  assign w_commit = Reset & (r_state == WR_HOLD) & ~w_wr & r_cap_inr;

  sram_responder_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (Clk),
    .i_we    (w_commit),
    .i_be    (r_cap_be),
    .i_waddr (r_cap_addr[AW-1:0]),
    .i_wdata (r_cap_data),
    .i_raddr (r_cap_addr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cap_addr <= '1;
      r_cap_data <= '1;
      r_cap_be   <= 2'b00;
      r_cap_inr  <= 1'b0;
      r_rd_inr   <= 1'b0;
      r_drive    <= 2'b00;
    end else begin
      r_rd_inr <= r_cap_inr;
      case (r_state)
        IDLE: begin
          if (w_wr) begin
            r_state    <= WR_HOLD;
            r_cap_addr <= ADDR;
            r_cap_data <= Data_In;
            r_cap_be   <= ~{UB, LB};
            r_cap_inr  <= w_in_range;
          end else if (w_rd) begin
            r_state    <= RD_WAIT;
            r_cnt      <= C_LAT_LOAD;
            r_cap_addr <= ADDR;
            r_cap_inr  <= w_in_range;
          end
        end

        RD_WAIT: begin
          if (w_wr) begin
            r_state    <= WR_HOLD;
            r_cap_addr <= ADDR;
            r_cap_data <= Data_In;
            r_cap_be   <= ~{UB, LB};
            r_cap_inr  <= w_in_range;
          end else if (!w_rd) begin
            r_state <= IDLE;
          end else if (w_addr_chg) begin
            // New address restarts the full latency.
            r_cnt      <= C_LAT_LOAD;
            r_cap_addr <= ADDR;
            r_cap_inr  <= w_in_range;
          end else if (r_cnt == '0) begin
            r_state <= RD_DRIVE;
            r_drive <= ~{UB, LB};
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        RD_DRIVE: begin
          r_drive <= 2'b00;
          if (w_wr) begin
            r_state    <= WR_HOLD;
            r_cap_addr <= ADDR;
            r_cap_data <= Data_In;
            r_cap_be   <= ~{UB, LB};
            r_cap_inr  <= w_in_range;
          end else if (!w_rd) begin
            r_state <= IDLE;
          end else if (w_addr_chg) begin
            r_state    <= RD_WAIT;
            r_cnt      <= C_LAT_LOAD;
            r_cap_addr <= ADDR;
            r_cap_inr  <= w_in_range;
          end else begin
            r_drive <= ~{UB, LB};
          end
        end

        WR_HOLD: begin
          if (w_wr) begin
            r_cap_addr <= ADDR;
            r_cap_data <= Data_In;
            r_cap_be   <= ~{UB, LB};
            r_cap_inr  <= w_in_range;
          end else if (w_rd) begin
            // Commit happens on this edge; the read goes straight to waiting.
            r_state    <= RD_WAIT;
            r_cnt      <= C_LAT_LOAD;
            r_cap_addr <= ADDR;
            r_cap_inr  <= w_in_range;
          end else begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign Data_Out   = {(r_drive[1] & r_rd_inr) ? w_rdata[15:8] : 8'h00,
                       (r_drive[0] & r_rd_inr) ? w_rdata[7:0]  : 8'h00};
  assign Data_Drive = r_drive;
  assign Busy       = (r_state == RD_WAIT) || (r_state == WR_HOLD);

`ifdef SRAM_RESPONDER_CONTENTION_CHECK_EN
  logic r_contention;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_contention <= 1'b0;
    end else if ((~CE & ~WE & ~OE) || ((|r_drive) && !WE)) begin
      r_contention <= 1'b1;
    end
  end

  assign Contention = r_contention;
`endif

endmodule : sram_responder
`default_nettype wire
